// File: rtl/bram_stream_reader_if.sv
// Bundle of control, BRAM-port and AXI4-Stream signals for bram_stream_reader.
// The master modport is the reader's view; slave is the view of its surroundings.
interface bram_stream_reader_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_LEN_WIDTH  = 16
);
  localparam int NUM_BYTES = C_DATA_WIDTH / 8;

  logic                    start;
  logic [C_ADDR_WIDTH-1:0] base_addr;
  logic [C_LEN_WIDTH-1:0]  num_words;
  logic                    busy;
  logic                    done;

  logic                    bram_en;
  logic [NUM_BYTES-1:0]    bram_we;
  logic [C_ADDR_WIDTH-1:0] bram_addr;
  logic [C_DATA_WIDTH-1:0] bram_din;
  logic [C_DATA_WIDTH-1:0] bram_dout;

  logic [C_DATA_WIDTH-1:0] m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;

  modport master (
    input  start, base_addr, num_words, bram_dout, m_axis_tready,
    output busy, done, bram_en, bram_we, bram_addr, bram_din,
           m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output start, base_addr, num_words, bram_dout, m_axis_tready,
    input  busy, done, bram_en, bram_we, bram_addr, bram_din,
           m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Drains a contiguous word region of a BRAM read port onto an AXI4-Stream master,
// one read per cycle, with a 2-entry output FIFO absorbing the 1-cycle read latency.
module bram_stream_reader #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  bram_stream_reader_if.master  bus
);
  localparam int NUM_BYTES = C_DATA_WIDTH / 8;
  localparam int LOW_BITS  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 0;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP = C_ADDR_WIDTH'(NUM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic [C_ADDR_WIDTH-1:0] align_addr(input logic [C_ADDR_WIDTH-1:0] a);
    return (a >> LOW_BITS) << LOW_BITS;
  endfunction

  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0]  rd_left_q, rd_left_d;
  logic [C_LEN_WIDTH-1:0]  out_left_q, out_left_d;
  logic                    done_q, done_d;
  logic                    inflight_q;
  logic [C_DATA_WIDTH-1:0] fifo_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q;

  logic                    pop_s;
  logic [1:0]              occ_s;
  logic                    issue_s;

  assign pop_s   = (count_q != 2'd0) && bus.m_axis_tready;
  assign occ_s   = count_q + {1'b0, inflight_q};
  // A slot freed by this cycle's handshake may be refilled by a read issued in the same cycle.
  assign issue_s = (state_q == S_READ) &&
                   ((occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    done_d     = 1'b0;
    if (pop_s) begin
      out_left_d = out_left_q - C_LEN_WIDTH'(1);
    end else begin
      out_left_d = out_left_q;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_words != C_LEN_WIDTH'(0)) begin
            state_d    = S_READ;
            addr_d     = align_addr(bus.base_addr);
            rd_left_d  = bus.num_words;
            out_left_d = bus.num_words;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (issue_s) begin
          addr_d    = addr_q + ADDR_STEP;
          rd_left_d = rd_left_q - C_LEN_WIDTH'(1);
          if (rd_left_q == C_LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        // Finish when the FIFO empties this cycle, so done lands right after the last beat.
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop_s))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= issue_s;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= bus.bram_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop_s};
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = done_q;
  assign bus.bram_en       = issue_s;
  assign bus.bram_we       = '0;
  assign bus.bram_addr     = addr_q;
  assign bus.bram_din      = '0;
  assign bus.m_axis_tvalid = (count_q != 2'd0);
  assign bus.m_axis_tdata  = fifo_q[rd_ptr_q];
  assign bus.m_axis_tlast  = (count_q != 2'd0) && (out_left_q == C_LEN_WIDTH'(1));
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Sequential reader that drains a contiguous word region of a true-dual-port block RAM port onto an AXI4-Stream master interface. It sits on the opposite side of the BRAM from the host writer: the host fills memory through one port, then pulses `start`, and this block drives the other port, issuing word reads at full throughput under stream backpressure. Memory addressing is byte-based; the RAM truncates low bits to word granularity with a fixed read latency of 1 cycle.

## Interface
- `C_DATA_WIDTH`, 32: word and stream data width; must be a multiple of 8. NUM_BYTES = C_DATA_WIDTH/8.
- `C_ADDR_WIDTH`, 4: BRAM byte-address width. LOW_BITS = log2(NUM_BYTES).
- `C_LEN_WIDTH`, 16: width of the word-count field.
- `aclk` in 1: single clock for all logic and the BRAM port.
- `areset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only while idle.
- `base_addr` in C_ADDR_WIDTH: byte address of the first word; low LOW_BITS bits ignored.
- `num_words` in C_LEN_WIDTH: words to transfer; 0 is legal.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at transfer end.
- `bram_en` out 1: BRAM port enable (read strobe).
- `bram_we` out NUM_BYTES: constant 0.
- `bram_addr` out C_ADDR_WIDTH: byte address; low LOW_BITS bits always 0.
- `bram_din` out C_DATA_WIDTH: constant 0.
- `bram_dout` in C_DATA_WIDTH: read data, valid 1 cycle after `bram_en`.
- `m_axis_tdata` out C_DATA_WIDTH: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: marks final word.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: `start`=1 with `num_words`>0 latches base (low bits zeroed) and count, goes to READ. `start`=1 with `num_words`=0 pulses `done` next cycle, emits no beats, stays IDLE, `busy` stays 0.
- READ: issues one read per cycle while allowed; `bram_addr` advances by NUM_BYTES per issued read and wraps modulo 2^C_ADDR_WIDTH. After the last read is issued, goes to DRAIN.
- DRAIN: waits until the output buffer is empty and nothing is in flight, then pulses `done` and returns to IDLE.
- Output buffer: 2-entry FIFO. A 1-bit in-flight flag mirrors `bram_en` of the previous cycle; when set, `bram_dout` is pushed into the FIFO.
- Issue rule: read allowed when (fifo_count + inflight) < 2, or == 2 and a stream handshake occurs this cycle. This gives 1 word/cycle with `m_axis_tready` held high, and the FIFO never overflows.
- `m_axis_tvalid` = FIFO non-empty; `m_axis_tdata` = FIFO head. Once asserted, `tvalid`/`tdata` stay stable until the handshake.
- `m_axis_tlast` = 1 exactly on the beat whose index is num_words-1.
- `start` while `busy` is ignored.
- Word count is tracked internally with C_LEN_WIDTH bits; num_words = 2^C_LEN_WIDTH-1 must work.

## Timing
- Reset values, applied on the next edge: all outputs 0, FSM IDLE, FIFO empty, in-flight flag cleared. Reset mid-transfer discards buffered and in-flight data; no `done` pulse is issued.
- Cycle 0: `start` sampled. Cycle 1: `busy`=1, `bram_en`=1, `bram_addr`=base. Cycle 2: `bram_dout` valid and pushed. Cycle 3: `m_axis_tvalid`=1 with word 0.
- First-beat latency is 3 cycles from the `start` sample.
- With continuous ready, N words occupy cycles 3..N+2. `done`=1 and `busy`=0 in the cycle after the final handshake (cycle N+3).
- Backpressure: holding `tready` low stops issue once the FIFO holds 2 entries or 1 entry plus one in flight. No data is lost or duplicated.
- `done` with num_words=0: cycle 1.

## Test plan
- Reset then `start`, base=0x0, num_words=4, ready high, BRAM preloaded 0x11,0x22,0x33,0x44 -> beats in cycles 3-6 in order, `tlast` on 0x44, `done` in cycle 7, `bram_addr` sequence 0x0,0x4,0x8,0xC.
- base=0xC, num_words=3 (C_ADDR_WIDTH=4) -> `bram_addr` 0xC,0x0,0x4, i.e. wrap; data order preserved.
- base=0x6 -> first `bram_addr`=0x4 (low bits dropped).
- num_words=8 with `tready` toggling 1,0,0,1,… pseudo-randomly -> exactly 8 beats, correct order, `tvalid`/`tdata` stable while stalled, in-flight + FIFO never exceeds 2.
- num_words=0 -> `done` in cycle 1, no `tvalid`, `busy` never set. `start` asserted mid-transfer -> ignored.
- `areset` asserted at beat 2 of 6 -> all outputs 0 next cycle, no `done`. A new `start` after reset transfers correctly from scratch.
